// File: rtl/jkq_pkg.sv
// Shared types and default widths for the JK flip-flop q monitor.
//   state_t : observer FSM states
//   rpt_t   : report payload {level, len} at the default run-length width
package jkq_pkg;

  localparam int unsigned LEN_W_DEF     = 8;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned STUCK_LIM_DEF = 20;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    STUCK
  } state_t;

  typedef struct packed {
    logic                 level;
    logic [LEN_W_DEF-1:0] len;
  } rpt_t;

endpackage

// File: rtl/jkq_sync.sv
// Two-flop synchronizer for the monitored q line.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, flops clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output (two edges of delay)
module jkq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/jk_q_monitor.sv
// Observer of a JK flip-flop output. Samples q every clock, measures runs of
// constant level, counts rising/falling edges, flags a stuck q and hands each
// completed run to a consumer through a one-entry valid/ready report buffer.
// Build option: define JKQ_SYNC_EN to route q_in through a two-flop
// synchronizer ahead of the sample flop (report latency 4 edges instead of 2).
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   q_in                  : monitored q
//   clr                   : synchronous clear of counters, flags, pending report
//   rpt_valid / rpt_ready : report handshake
//   rpt_level / rpt_len   : level and saturating length of the completed run
//   rise_cnt / fall_cnt   : wrapping 0->1 / 1->0 transition counters
//   stuck                 : current run length >= STUCK_LIM
//   ovf                   : sticky, a report was dropped
module jk_q_monitor
  import jkq_pkg::*;
#(
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned STUCK_LIM = STUCK_LIM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clr,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic             rpt_level,
  output logic [LEN_W-1:0] rpt_len,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             stuck,
  output logic             ovf
);

  // Same layout as jkq_pkg::rpt_t, sized by this instance's LEN_W.
  typedef struct packed {
    logic             level;
    logic [LEN_W-1:0] len;
  } rpt_w_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LIM     = LEN_W'(STUCK_LIM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Edges after reset release until q_s_q holds a genuine sample of q_in.
`ifdef JKQ_SYNC_EN
  localparam logic [1:0] FILL_EDGES = 2'd3;
`else
  localparam logic [1:0] FILL_EDGES = 2'd1;
`endif

  logic q_src;

`ifdef JKQ_SYNC_EN
  jkq_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (q_in),
    .q_o    (q_src)
  );
`else
  assign q_src = q_in;
`endif

  logic             q_s_q;
  logic [1:0]       fill_q;
  logic             filled;
  state_t           state_q,     state_d;
  logic             q_last_q,    q_last_d;
  logic [LEN_W-1:0] run_len_q,   run_len_d;
  logic             stuck_q,     stuck_d;
  logic [CNT_W-1:0] rise_q,      rise_d;
  logic [CNT_W-1:0] fall_q,      fall_d;
  logic             ovf_q,       ovf_d;
  logic             rpt_valid_q, rpt_valid_d;
  rpt_w_t           rpt_q,       rpt_d;
  logic             accept;

  assign filled = (fill_q == FILL_EDGES);
  assign accept = rpt_valid_q && rpt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      q_s_q <= q_src;
      if (!filled) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      q_last_q    <= 1'b0;
      run_len_q   <= '0;
      stuck_q     <= 1'b0;
      rise_q      <= '0;
      fall_q      <= '0;
      ovf_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_q       <= '0;
    end else begin
      state_q     <= state_d;
      q_last_q    <= q_last_d;
      run_len_q   <= run_len_d;
      stuck_q     <= stuck_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      ovf_q       <= ovf_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_q       <= rpt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    q_last_d    = q_last_q;
    run_len_d   = run_len_q;
    stuck_d     = stuck_q;
    rise_d      = rise_q;
    fall_d      = fall_q;
    ovf_d       = ovf_q;
    rpt_valid_d = rpt_valid_q;
    rpt_d       = rpt_q;

    if (accept) begin
      rpt_valid_d = 1'b0;
    end

    // clr overrides a coincident run end: nothing is reported or counted.
    if (clr) begin
      state_d     = INIT;
      run_len_d   = '0;
      stuck_d     = 1'b0;
      rise_d      = '0;
      fall_d      = '0;
      ovf_d       = 1'b0;
      rpt_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (filled) begin
            q_last_d  = q_s_q;
            run_len_d = LEN_ONE;
            state_d   = RUN;
          end
        end
        RUN, STUCK: begin
          if (q_s_q == q_last_q) begin
            if (run_len_q != LEN_MAX) begin
              run_len_d = run_len_q + LEN_ONE;
            end
            if (run_len_d >= LIM) begin
              stuck_d = 1'b1;
              state_d = STUCK;
            end
          end else begin
            // Buffer takes the new report if empty or being drained this cycle;
            // otherwise the old payload is kept and the loss is flagged.
            if (!rpt_valid_q || accept) begin
              rpt_d.level = q_last_q;
              rpt_d.len   = run_len_q;
              rpt_valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
            if (q_s_q) begin
              rise_d = rise_q + CNT_ONE;
            end else begin
              fall_d = fall_q + CNT_ONE;
            end
            q_last_d  = q_s_q;
            run_len_d = LEN_ONE;
            stuck_d   = 1'b0;
            state_d   = RUN;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_level = rpt_q.level;
  assign rpt_len   = rpt_q.len;
  assign rise_cnt  = rise_q;
  assign fall_cnt  = fall_q;
  assign stuck     = stuck_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jk_q_monitor.sv
// Directed self-checking bench for jk_q_monitor. Instance A uses default
// parameters; instance B uses LEN_W=4, STUCK_LIM=10 to exercise saturation.
// Expected timing follows the build: L edges from q_in change to rpt_valid.
module tb_jk_q_monitor;

`ifdef JKQ_SYNC_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr;

  logic        q_a, ready_a, valid_a, level_a, stuck_a, ovf_a;
  logic [7:0]  len_a;
  logic [15:0] rise_a, fall_a;

  logic        q_b, ready_b, valid_b, level_b, stuck_b, ovf_b;
  logic [3:0]  len_b;
  logic [15:0] rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  jk_q_monitor u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_in      (q_a),
    .clr       (clr),
    .rpt_valid (valid_a),
    .rpt_ready (ready_a),
    .rpt_level (level_a),
    .rpt_len   (len_a),
    .rise_cnt  (rise_a),
    .fall_cnt  (fall_a),
    .stuck     (stuck_a),
    .ovf       (ovf_a)
  );

  jk_q_monitor #(
    .LEN_W     (4),
    .CNT_W     (16),
    .STUCK_LIM (10)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_in      (q_b),
    .clr       (clr),
    .rpt_valid (valid_b),
    .rpt_ready (ready_b),
    .rpt_level (level_b),
    .rpt_len   (len_b),
    .rise_cnt  (rise_b),
    .fall_cnt  (fall_b),
    .stuck     (stuck_b),
    .ovf       (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after an edge; release lands mid-cycle so the next edge is E1.
  task automatic do_reset();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    clr     = 1'b0;
    q_a     = 1'b0;
    q_b     = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_len",   32'(len_a),   32'd0);
    check("rst_rise",  32'(rise_a),  32'd0);
    check("rst_stuck", 32'(stuck_a), 32'd0);
    check("rst_ovf",   32'(ovf_a),   32'd0);
    check("rst_b_valid", 32'(valid_b), 32'd0);
    step(1);

    // Toggle every 3 cycles with the consumer stalled: first report held, second dropped.
    q_a = 1'b0; ready_a = 1'b0;
    do_reset();
    step(3);
    q_a = 1'b1;
    step(L - 1);
    check("t2_not_yet", 32'(valid_a), 32'd0);
    step(4 - L);
    q_a = 1'b0;
    step(L - 1);
    check("t2_valid",  32'(valid_a), 32'd1);
    check("t2_level",  32'(level_a), 32'd0);
    check("t2_len",    32'(len_a),   32'd3);
    check("t2_ovf0",   32'(ovf_a),   32'd0);
    check("t2_rise",   32'(rise_a),  32'd1);
    step(1);
    check("t2_ovf1",   32'(ovf_a),   32'd1);
    check("t2_hold_v", 32'(valid_a), 32'd1);
    check("t2_hold_l", 32'(level_a), 32'd0);
    check("t2_hold_n", 32'(len_a),   32'd3);
    check("t2_fall",   32'(fall_a),  32'd1);

    // Basic run: 6 zero samples then 1, consumer ready.
    q_a = 1'b0; ready_a = 1'b1;
    do_reset();
    step(6);
    q_a = 1'b1;
    step(L - 1);
    check("t1_not_yet", 32'(valid_a), 32'd0);
    step(1);
    check("t1_valid", 32'(valid_a), 32'd1);
    check("t1_level", 32'(level_a), 32'd0);
    check("t1_len",   32'(len_a),   32'd6);
    check("t1_rise",  32'(rise_a),  32'd1);
    check("t1_fall",  32'(fall_a),  32'd0);
    check("t1_ovf",   32'(ovf_a),   32'd0);
    step(1);
    check("t1_accepted", 32'(valid_a), 32'd0);

    // Stuck detection: 25 ones then a fall.
    q_a = 1'b1; ready_a = 1'b1;
    do_reset();
    step(18 + L);
    check("t3_stuck_19", 32'(stuck_a), 32'd0);
    step(1);
    check("t3_stuck_20", 32'(stuck_a), 32'd1);
    step(6 - L);
    q_a = 1'b0;
    step(L - 1);
    check("t3_stuck_hold", 32'(stuck_a), 32'd1);
    check("t3_no_rpt",     32'(valid_a), 32'd0);
    step(1);
    check("t3_stuck_clr", 32'(stuck_a), 32'd0);
    check("t3_valid",     32'(valid_a), 32'd1);
    check("t3_level",     32'(level_a), 32'd1);
    check("t3_len",       32'(len_a),   32'd25);
    check("t3_fall",      32'(fall_a),  32'd1);
    check("t3_rise",      32'(rise_a),  32'd0);

    // Saturation on the narrow instance: 30 zeros reported as 15.
    q_b = 1'b0;
    do_reset();
    step(30);
    check("t4_stuck", 32'(stuck_b), 32'd1);
    q_b = 1'b1;
    step(L);
    check("t4_valid", 32'(valid_b), 32'd1);
    check("t4_level", 32'(level_b), 32'd0);
    check("t4_len",   32'(len_b),   32'd15);
    check("t4_rise",  32'(rise_b),  32'd1);
    check("t4_fall",  32'(fall_b),  32'd0);
    check("t4_ovf",   32'(ovf_b),   32'd0);

    // Asynchronous reset while a report is pending and q is stuck.
    q_a = 1'b0; ready_a = 1'b0;
    do_reset();
    step(3);
    q_a = 1'b1;
    step(27);
    check("t5_pre_stuck", 32'(stuck_a), 32'd1);
    check("t5_pre_valid", 32'(valid_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(valid_a), 32'd0);
    check("t5_stuck", 32'(stuck_a), 32'd0);
    check("t5_rise",  32'(rise_a),  32'd0);
    check("t5_len",   32'(len_a),   32'd0);
    #1;
    rst_n = 1'b1;
    step(5);
    q_a = 1'b0;
    step(L - 1);
    check("t5_no_rpt", 32'(valid_a), 32'd0);
    step(1);
    check("t5_valid2", 32'(valid_a), 32'd1);
    check("t5_level2", 32'(level_a), 32'd1);
    check("t5_len2",   32'(len_a),   32'd5);
    check("t5_fall2",  32'(fall_a),  32'd1);

    // clr on the same edge as a run end.
    q_a = 1'b0; ready_a = 1'b1;
    do_reset();
    step(5);
    q_a = 1'b1;
    step(L - 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t6_valid", 32'(valid_a), 32'd0);
    check("t6_rise",  32'(rise_a),  32'd0);
    check("t6_fall",  32'(fall_a),  32'd0);
    check("t6_ovf",   32'(ovf_a),   32'd0);
    check("t6_stuck", 32'(stuck_a), 32'd0);
    step(5 - L);
    q_a = 1'b0;
    step(L);
    check("t6_valid2", 32'(valid_a), 32'd1);
    check("t6_level2", 32'(level_a), 32'd1);
    check("t6_len2",   32'(len_a),   32'd4);
    check("t6_rise2",  32'(rise_a),  32'd0);
    check("t6_fall2",  32'(fall_a),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
